mult_div_ctrl: RTL and testbench
================================

Name: mult_div_ctrl

Overview:
- Sequencing controller for the EX-stage multiply/divide unit of the MIPS core.
- Decodes HI/LO-class instructions and launches the shared unit with a start/done handshake.
- Raises a pipeline stall until the 64-bit result is committed, and owns the architectural HI/LO registers.
- Multiply uses a fixed pipeline latency. Divide is iterative and completes on the unit's done pulse.

Parameters:
- MULT_LATENCY, 2: cycles from unit_start to a valid multiply result on unit_result. Legal range 1..15.
- CNT_W, 4: width of the latency counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- stall_all  in  1  global pipeline freeze.
- flush  in  1  kill the EX-stage instruction.
- op_valid  in  1  EX stage holds a valid instruction.
- funct  in  6  MIPS funct field.
- operand_1  in  32  rs value.
- operand_2  in  32  rt value.
- unit_start  out  1  one-cycle launch pulse to the unit.
- unit_is_div  out  1  1 = divide, 0 = multiply; held stable while busy.
- unit_signed  out  1  1 = signed op; held stable while busy.
- unit_op1  out  32  latched operand_1.
- unit_op2  out  32  latched operand_2.
- unit_cancel  out  1  one-cycle abort pulse to the unit.
- unit_done  in  1  divide-complete pulse.
- unit_result  in  64  {HI, LO} result from the unit.
- stall_req  out  1  hold IF/ID/EX.
- hilo_busy  out  1  controller not IDLE.
- hi  out  32  architectural HI.
- lo  out  32  architectural LO.

Behaviour:
- Reset (rst=0, async): state=IDLE; hi=lo=0; result buffer=0; counter=0; all unit_* outputs=0; stall_req=0.
- Decode:
  - MULT=0x18, MULTU=0x19, DIV=0x1A, DIVU=0x1B.
  - MTHI=0x11, MTLO=0x13.
  - All other functs are ignored.
  - unit_signed=1 for 0x18 and 0x1A.
- accept = IDLE & op_valid & !stall_all & !flush & funct is one of the four mult/div codes.
- State IDLE:
  - On accept: latch operands, unit_is_div and unit_signed.
  - Multiply: pulse unit_start, clear the counter, go MUL_WAIT.
  - Divide with operand_2==0: do NOT start the unit. Load buffer = {operand_1, 32'hFFFF_FFFF} and go DONE.
  - Divide with operand_2!=0: pulse unit_start, go DIV_WAIT.
  - MTHI/MTLO (op_valid, !stall_all, !flush): write hi or lo with operand_1 at the next edge. No stall, state stays IDLE.
- State MUL_WAIT:
  - Counter increments every cycle, independent of stall_all.
  - When counter==MULT_LATENCY-1: buffer <= unit_result, go DONE.
- State DIV_WAIT:
  - On unit_done: buffer <= unit_result, go DONE.
  - Captured regardless of stall_all, because unit_done is a single-cycle pulse.
- State DONE:
  - If !stall_all: {hi,lo} <= buffer, go IDLE.
  - Else hold in DONE.
- stall_req:
  - 1 in the accept cycle and in MUL_WAIT and DIV_WAIT.
  - 0 in DONE, so the instruction leaves EX on the same edge that commits HI/LO.
  - 0 in IDLE when not accepting.
- hilo_busy = (state != IDLE).
- Flush:
  - In any non-IDLE state: go IDLE, no HI/LO write, pulse unit_cancel if the state was MUL_WAIT or DIV_WAIT.
  - Flush has priority over stall_all and over unit_done in the same cycle.
- unit_done outside DIV_WAIT is ignored.
- A new op cannot be accepted in the commit cycle; the next accept occurs in IDLE one cycle later at the earliest.
- Reset mid-operation: immediate return to reset values. unit_cancel is not pulsed.
- unit_start and unit_cancel are never high together.

Test Plan:
- MULT op1=0xFFFF_FFFE (-2), op2=3, MULT_LATENCY=2, unit returns 0xFFFF_FFFF_FFFF_FFFA at count 1 -> unit_start one pulse, unit_signed=1; stall_req high 3 cycles; hi=0xFFFF_FFFF, lo=0xFFFF_FFFA one cycle after DONE.
- DIVU op1=100, op2=7, unit_done after 33 cycles with {2,14} -> stall_req held throughout; hi=2, lo=14 committed; unit_is_div=1, unit_signed=0.
- DIV op2=0, op1=0x1234 -> no unit_start; DONE next cycle; hi=0x1234, lo=0xFFFF_FFFF; stall_req high exactly 1 cycle.
- DIVU in progress, stall_all high across unit_done and 4 further cycles -> result buffered, state stays DONE, hi/lo unchanged; commit on the first cycle stall_all=0.
- flush in DIV_WAIT coincident with unit_done -> unit_cancel single pulse, state IDLE, hi/lo keep prior values; then MTLO op1=0xA5A5_A5A5 -> lo=0xA5A5_A5A5 next edge, stall_req never asserted.
- rst low mid MUL_WAIT -> all outputs zero immediately (async), hi=lo=0, state IDLE after release.

Source files
------------

// File: rtl/mult_div_ctrl.sv
// mult_div_ctrl: EX-stage sequencer for the shared multiply/divide unit.
// Launches the unit, stalls the pipe until the 64-bit result is committed,
// and owns the architectural HI/LO registers.
module mult_div_ctrl #(
    parameter int unsigned MULT_LATENCY = 2,
    parameter int unsigned CNT_W        = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_all_i,
    input  logic        flush_i,
    input  logic        op_valid_i,
    input  logic [5:0]  funct_i,
    input  logic [31:0] operand_1_i,
    input  logic [31:0] operand_2_i,
    output logic        unit_start_o,
    output logic        unit_is_div_o,
    output logic        unit_signed_o,
    output logic [31:0] unit_op1_o,
    output logic [31:0] unit_op2_o,
    output logic        unit_cancel_o,
    input  logic        unit_done_i,
    input  logic [63:0] unit_result_i,
    output logic        stall_req_o,
    output logic        hilo_busy_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    localparam int unsigned XLEN    = 32;
    localparam int unsigned RES_W   = 2 * XLEN;
    localparam int unsigned FUNCT_W = 6;

    localparam logic [FUNCT_W-1:0] F_MTHI  = 6'h11;
    localparam logic [FUNCT_W-1:0] F_MTLO  = 6'h13;
    localparam logic [FUNCT_W-1:0] F_MULT  = 6'h18;
    localparam logic [FUNCT_W-1:0] F_MULTU = 6'h19;
    localparam logic [FUNCT_W-1:0] F_DIV   = 6'h1A;
    localparam logic [FUNCT_W-1:0] F_DIVU  = 6'h1B;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MULT_LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_MUL_WAIT = 2'd1,
        S_DIV_WAIT = 2'd2,
        S_DONE     = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [RES_W-1:0]  buf_q, buf_d;
    logic [XLEN-1:0]   hi_q, hi_d;
    logic [XLEN-1:0]   lo_q, lo_d;
    logic              is_div_q, is_div_d;
    logic              signed_q, signed_d;
    logic [XLEN-1:0]   op1_q, op1_d;
    logic [XLEN-1:0]   op2_q, op2_d;

    logic              issue_ok;
    logic              is_muldiv;
    logic              dec_div;
    logic              dec_signed;
    logic              div_by_zero;

    // Instruction decode; issue is also blocked while reset is asserted
    assign issue_ok    = rst_n & op_valid_i & ~stall_all_i & ~flush_i;
    assign is_muldiv   = (funct_i == F_MULT) | (funct_i == F_MULTU) |
                         (funct_i == F_DIV)  | (funct_i == F_DIVU);
    assign dec_div     = (funct_i == F_DIV)  | (funct_i == F_DIVU);
    assign dec_signed  = (funct_i == F_MULT) | (funct_i == F_DIV);
    assign div_by_zero = dec_div & (operand_2_i == '0);

    // State register and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            buf_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            is_div_q <= 1'b0;
            signed_q <= 1'b0;
            op1_q    <= '0;
            op2_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            buf_q    <= buf_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            is_div_q <= is_div_d;
            signed_q <= signed_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
        end
    end

    // Next-state, launch/cancel pulses and stall generation
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        buf_d         = buf_q;
        hi_d          = hi_q;
        lo_d          = lo_q;
        is_div_d      = is_div_q;
        signed_d      = signed_q;
        op1_d         = op1_q;
        op2_d         = op2_q;
        unit_start_o  = 1'b0;
        unit_cancel_o = 1'b0;
        stall_req_o   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (issue_ok && is_muldiv) begin
                    stall_req_o = 1'b1;
                    op1_d       = operand_1_i;
                    op2_d       = operand_2_i;
                    is_div_d    = dec_div;
                    signed_d    = dec_signed;
                    if (div_by_zero) begin
                        // Divide by zero never reaches the unit
                        buf_d   = {operand_1_i, {XLEN{1'b1}}};
                        state_d = S_DONE;
                    end else begin
                        unit_start_o = 1'b1;
                        cnt_d        = '0;
                        state_d      = dec_div ? S_DIV_WAIT : S_MUL_WAIT;
                    end
                end else if (issue_ok) begin
                    if (funct_i == F_MTHI) hi_d = operand_1_i;
                    if (funct_i == F_MTLO) lo_d = operand_1_i;
                end
            end
            S_MUL_WAIT: begin
                stall_req_o = 1'b1;
                cnt_d       = cnt_q + CNT_W'(1);
                if (flush_i) begin
                    unit_cancel_o = 1'b1;
                    state_d       = S_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    buf_d   = unit_result_i;
                    state_d = S_DONE;
                end
            end
            S_DIV_WAIT: begin
                stall_req_o = 1'b1;
                if (flush_i) begin
                    unit_cancel_o = 1'b1;
                    state_d       = S_IDLE;
                end else if (unit_done_i) begin
                    buf_d   = unit_result_i;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (flush_i) begin
                    state_d = S_IDLE;
                end else if (!stall_all_i) begin
                    hi_d    = buf_q[RES_W-1:XLEN];
                    lo_d    = buf_q[XLEN-1:0];
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Register-driven outputs
    assign unit_is_div_o = is_div_q;
    assign unit_signed_o = signed_q;
    assign unit_op1_o    = op1_q;
    assign unit_op2_o    = op2_q;
    assign hilo_busy_o   = (state_q != S_IDLE);
    assign hi_o          = hi_q;
    assign lo_o          = lo_q;

endmodule

// File: tb/tb_mult_div_ctrl.sv
// tb_mult_div_ctrl: randomized bench with a transaction-level reference model
// and a behavioural multiply/divide unit.
module tb_mult_div_ctrl;

    localparam int LAT = 2;

    logic        clk;
    logic        rst_n;
    logic        stall_all_i;
    logic        flush_i;
    logic        op_valid_i;
    logic [5:0]  funct_i;
    logic [31:0] operand_1_i;
    logic [31:0] operand_2_i;
    logic        unit_start_o;
    logic        unit_is_div_o;
    logic        unit_signed_o;
    logic [31:0] unit_op1_o;
    logic [31:0] unit_op2_o;
    logic        unit_cancel_o;
    logic        unit_done_i;
    logic [63:0] unit_result_i;
    logic        stall_req_o;
    logic        hilo_busy_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    mult_div_ctrl #(.MULT_LATENCY(LAT), .CNT_W(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall_all_i  (stall_all_i),
        .flush_i      (flush_i),
        .op_valid_i   (op_valid_i),
        .funct_i      (funct_i),
        .operand_1_i  (operand_1_i),
        .operand_2_i  (operand_2_i),
        .unit_start_o (unit_start_o),
        .unit_is_div_o(unit_is_div_o),
        .unit_signed_o(unit_signed_o),
        .unit_op1_o   (unit_op1_o),
        .unit_op2_o   (unit_op2_o),
        .unit_cancel_o(unit_cancel_o),
        .unit_done_i  (unit_done_i),
        .unit_result_i(unit_result_i),
        .stall_req_o  (stall_req_o),
        .hilo_busy_o  (hilo_busy_o),
        .hi_o         (hi_o),
        .lo_o         (lo_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: an op is either waiting on the unit (pend) or holding
    // a finished result (ready); neither means the controller is free.
    logic        m_pend, m_ready, m_isdiv, m_sgn;
    logic [31:0] m_op1, m_op2, m_hi, m_lo;
    logic [63:0] m_buf;
    int          m_since, m_div_left;
    logic        rand_mode;
    int          div_delay;
    int          cnt_stall, cnt_start, cnt_cancel;

    function automatic logic [63:0] mul_ref(input logic s, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] xa, xb;
        xa = s ? {{32{a[31]}}, a} : {32'b0, a};
        xb = s ? {{32{b[31]}}, b} : {32'b0, b};
        return xa * xb;
    endfunction

    function automatic logic [63:0] div_ref(input logic s, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] qv, rv;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
            qv = 64'(q);
            rv = 64'(r);
            return {rv[31:0], qv[31:0]};
        end
        return {a % b, a / b};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    task automatic model_reset();
        m_pend = 1'b0; m_ready = 1'b0; m_isdiv = 1'b0; m_sgn = 1'b0;
        m_op1 = '0; m_op2 = '0; m_hi = '0; m_lo = '0; m_buf = '0;
        m_since = 0; m_div_left = 0;
    endtask

    task automatic clr_counts();
        cnt_stall = 0; cnt_start = 0; cnt_cancel = 0;
    endtask

    // One clock cycle: drive, compare every output against the model, advance the model
    task automatic step(input logic ov, input logic [5:0] fn, input logic [31:0] a,
                        input logic [31:0] b, input logic st, input logic fl);
        logic        acc, md, dv, sg, dz, ud;
        logic [63:0] ures;
        op_valid_i  = ov;
        funct_i     = fn;
        operand_1_i = a;
        operand_2_i = b;
        stall_all_i = st;
        flush_i     = fl;
        ud   = 1'b0;
        ures = {$urandom, $urandom};
        if (m_pend && m_isdiv) begin
            if (m_div_left == 0) begin
                ud   = 1'b1;
                ures = div_ref(m_sgn, m_op1, m_op2);
            end
        end else begin
            if (m_pend && m_since == LAT) ures = mul_ref(m_sgn, m_op1, m_op2);
            if (rand_mode && $urandom_range(0, 9) == 0) ud = 1'b1;
        end
        unit_done_i   = ud;
        unit_result_i = ures;
        #1;
        md  = (fn >= 6'h18) && (fn <= 6'h1B);
        dv  = (fn == 6'h1A) || (fn == 6'h1B);
        sg  = (fn == 6'h18) || (fn == 6'h1A);
        acc = !(m_pend || m_ready) && ov && !st && !fl && md;
        dz  = acc && dv && (b == 32'd0);
        chk("stall_req",   64'(stall_req_o),   64'(acc || m_pend));
        chk("unit_start",  64'(unit_start_o),  64'(acc && !dz));
        chk("unit_cancel", 64'(unit_cancel_o), 64'(m_pend && fl));
        chk("hilo_busy",   64'(hilo_busy_o),   64'(m_pend || m_ready));
        chk("hi",          64'(hi_o),          64'(m_hi));
        chk("lo",          64'(lo_o),          64'(m_lo));
        chk("unit_is_div", 64'(unit_is_div_o), 64'(m_isdiv));
        chk("unit_signed", 64'(unit_signed_o), 64'(m_sgn));
        chk("unit_op1",    64'(unit_op1_o),    64'(m_op1));
        chk("unit_op2",    64'(unit_op2_o),    64'(m_op2));
        if (stall_req_o)   cnt_stall++;
        if (unit_start_o)  cnt_start++;
        if (unit_cancel_o) cnt_cancel++;
        if (acc) begin
            m_isdiv = dv; m_sgn = sg; m_op1 = a; m_op2 = b;
            if (dz) begin
                m_ready = 1'b1;
                m_buf   = {a, 32'hFFFF_FFFF};
            end else begin
                m_pend     = 1'b1;
                m_since    = 1;
                m_div_left = rand_mode ? int'($urandom_range(0, 40)) : div_delay;
            end
        end else if (m_pend) begin
            if (fl) begin
                m_pend = 1'b0;
            end else if (!m_isdiv) begin
                if (m_since == LAT) begin
                    m_buf = mul_ref(m_sgn, m_op1, m_op2);
                    m_pend = 1'b0; m_ready = 1'b1;
                end else begin
                    m_since++;
                end
            end else if (ud) begin
                m_buf = ures;
                m_pend = 1'b0; m_ready = 1'b1;
            end else begin
                m_div_left--;
            end
        end else if (m_ready) begin
            if (fl) begin
                m_ready = 1'b0;
            end else if (!st) begin
                m_hi = m_buf[63:32];
                m_lo = m_buf[31:0];
                m_ready = 1'b0;
            end
        end else if (ov && !st && !fl) begin
            if (fn == 6'h11) m_hi = a;
            else if (fn == 6'h13) m_lo = a;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 6'h00, 32'd0, 32'd0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [5:0] fn;
        rst_n = 1'b0; stall_all_i = 1'b0; flush_i = 1'b0; op_valid_i = 1'b0;
        funct_i = '0; operand_1_i = '0; operand_2_i = '0;
        unit_done_i = 1'b0; unit_result_i = '0;
        rand_mode = 1'b0; div_delay = 0;
        model_reset();
        clr_counts();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset values
        idle(1);
        chk("rst_hi", 64'(hi_o), 64'h0);

        // MULT -2 * 3
        clr_counts();
        step(1'b1, 6'h18, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0);
        idle(4);
        chk("mult_stall_cycles", 64'(cnt_stall), 64'd3);
        chk("mult_start_pulses", 64'(cnt_start), 64'd1);
        chk("mult_hi", 64'(hi_o), 64'hFFFF_FFFF);
        chk("mult_lo", 64'(lo_o), 64'hFFFF_FFFA);
        chk("mult_signed", 64'(unit_signed_o), 64'd1);

        // DIVU 100 / 7, done 33 cycles after accept
        clr_counts();
        div_delay = 32;
        step(1'b1, 6'h1B, 32'd100, 32'd7, 1'b0, 1'b0);
        idle(36);
        chk("divu_stall_cycles", 64'(cnt_stall), 64'd34);
        chk("divu_hi", 64'(hi_o), 64'd2);
        chk("divu_lo", 64'(lo_o), 64'd14);
        chk("divu_is_div", 64'(unit_is_div_o), 64'd1);
        chk("divu_signed", 64'(unit_signed_o), 64'd0);

        // DIV by zero bypasses the unit
        clr_counts();
        step(1'b1, 6'h1A, 32'h1234, 32'd0, 1'b0, 1'b0);
        idle(3);
        chk("div0_stall_cycles", 64'(cnt_stall), 64'd1);
        chk("div0_start_pulses", 64'(cnt_start), 64'd0);
        chk("div0_hi", 64'(hi_o), 64'h1234);
        chk("div0_lo", 64'(lo_o), 64'hFFFF_FFFF);

        // DIVU 1000 / 7 with stall_all across unit_done and 4 more cycles
        div_delay = 3;
        step(1'b1, 6'h1B, 32'd1000, 32'd7, 1'b0, 1'b0);
        idle(3);
        for (int i = 0; i < 5; i++) step(1'b0, 6'h00, 32'd0, 32'd0, 1'b1, 1'b0);
        chk("stall_hold_busy", 64'(hilo_busy_o), 64'd1);
        chk("stall_hold_hi", 64'(hi_o), 64'h1234);
        chk("stall_hold_lo", 64'(lo_o), 64'hFFFF_FFFF);
        idle(2);
        chk("stall_commit_hi", 64'(hi_o), 64'd6);
        chk("stall_commit_lo", 64'(lo_o), 64'd142);

        // Flush in DIV_WAIT coincident with unit_done, then MTLO
        clr_counts();
        div_delay = 2;
        step(1'b1, 6'h1A, 32'd9, 32'd2, 1'b0, 1'b0);
        idle(2);
        step(1'b0, 6'h00, 32'd0, 32'd0, 1'b0, 1'b1);
        chk("flush_cancel_pulses", 64'(cnt_cancel), 64'd1);
        chk("flush_busy", 64'(hilo_busy_o), 64'd0);
        chk("flush_hi", 64'(hi_o), 64'd6);
        chk("flush_lo", 64'(lo_o), 64'd142);
        idle(2);
        clr_counts();
        step(1'b1, 6'h13, 32'hA5A5_A5A5, 32'd0, 1'b0, 1'b0);
        idle(1);
        chk("mtlo_lo", 64'(lo_o), 64'hA5A5_A5A5);
        chk("mtlo_hi", 64'(hi_o), 64'd6);
        chk("mtlo_stall_cycles", 64'(cnt_stall), 64'd0);

        // Async reset in the middle of MUL_WAIT
        step(1'b1, 6'h18, 32'd7, 32'd9, 1'b0, 1'b0);
        op_valid_i = 1'b1; funct_i = 6'h18; operand_2_i = 32'd5;
        rst_n = 1'b0;
        #1;
        chk("arst_stall_req", 64'(stall_req_o), 64'd0);
        chk("arst_start", 64'(unit_start_o), 64'd0);
        chk("arst_cancel", 64'(unit_cancel_o), 64'd0);
        chk("arst_busy", 64'(hilo_busy_o), 64'd0);
        chk("arst_hi", 64'(hi_o), 64'd0);
        chk("arst_lo", 64'(lo_o), 64'd0);
        chk("arst_is_div", 64'(unit_is_div_o), 64'd0);
        chk("arst_signed", 64'(unit_signed_o), 64'd0);
        chk("arst_op1", 64'(unit_op1_o), 64'd0);
        chk("arst_op2", 64'(unit_op2_o), 64'd0);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(2);

        // Randomized traffic
        rand_mode = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            case ($urandom_range(0, 7))
                0: fn = 6'h18;
                1: fn = 6'h19;
                2: fn = 6'h1A;
                3: fn = 6'h1B;
                4: fn = 6'h11;
                5: fn = 6'h13;
                default: fn = 6'($urandom);
            endcase
            step($urandom_range(0, 3) != 0, fn, $urandom,
                 ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
